// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction memory request/acknowledge bus
// Purpose: groups the fetch unit's memory access signals into one bundle.
// Signals:
//   mem_req    fetch -> mem  access request, held until mem_ack
//   mem_addr   fetch -> mem  word address, held until mem_ack
//   mem_ack    mem -> fetch  access complete, mem_rdata valid this cycle
//   mem_rdata  mem -> fetch  instruction word
// Modports: master (fetch side), slave (memory side).
interface fetch_sequencer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch PC owner and instruction fetch sequencer
// Purpose: issues in-order instruction fetches to a variable-latency memory,
// drains wrong-path accesses after branch/jump redirects, and holds fetched
// words in an output register backed by a one-entry skid buffer.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   PCSrcF        00 seq, 01 branch, 10 jump, 11 treated as seq
//   PCBranchF     branch target
//   PCjumpF       jump target
//   stallD        decode cannot accept this cycle
//   mem           memory bus (master modport of fetch_sequencer_if)
//   instrF, pcF   fetched instruction and its address
//   PCPlus4F      pcF + 4
//   validF        output fields are meaningful
//   timeout_err   sticky flag: an access stayed unacked past MAX_WAIT
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        PCSrcF,
  input  logic [31:0]       PCBranchF,
  input  logic [31:0]       PCjumpF,
  input  logic              stallD,
  fetch_sequencer_if.master mem,
  output logic [31:0]       instrF,
  output logic [31:0]       pcF,
  output logic [31:0]       PCPlus4F,
  output logic              validF,
  output logic              timeout_err
);
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  typedef enum logic [1:0] {ISSUE, DRAIN, SKID} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_d, pcf_d, plus4_d;
  logic        valid_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_d;

  logic        redirect, slot_free, consumed;
  logic [31:0] target;
  logic        req;
  logic [31:0] addr;

  assign mem.mem_req  = req;
  assign mem.mem_addr = addr;

  // A redirect is only honoured when decode is not stalled.
  always_comb begin
    redirect  = (PCSrcF == 2'b01 || PCSrcF == 2'b10) && !stallD;
    target    = ((PCSrcF == 2'b10) ? PCjumpF : PCBranchF) & 32'hFFFF_FFFC;
    slot_free = !validF || !stallD;
    consumed  = validF && !stallD;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instrF;
    pcf_d        = pcF;
    plus4_d      = PCPlus4F;
    valid_d      = validF;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_err;
    req          = 1'b0;
    addr         = pc_q;

    unique case (state_q)
      ISSUE: begin
        req = 1'b1;
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          // The outstanding access must still complete; remember its address.
          if (!mem.mem_ack) begin
            drain_addr_d = pc_q;
            state_d      = DRAIN;
          end
        end else if (mem.mem_ack) begin
          pc_d = pc_q + 32'd4;
          if (slot_free) begin
            instr_d = mem.mem_rdata;
            pcf_d   = pc_q;
            plus4_d = pc_q + 32'd4;
            valid_d = 1'b1;
          end else begin
            skid_instr_d = mem.mem_rdata;
            skid_pc_d    = pc_q;
            state_d      = SKID;
          end
        end else if (consumed) begin
          valid_d = 1'b0;
        end
      end
      DRAIN: begin
        req  = 1'b1;
        addr = drain_addr_q;
        if (redirect) pc_d = target;
        if (mem.mem_ack) state_d = ISSUE;
      end
      SKID: begin
        // No new request while the skid word waits for decode.
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = ISSUE;
        end else if (!stallD) begin
          instr_d = skid_instr_q;
          pcf_d   = skid_pc_q;
          plus4_d = skid_pc_q + 32'd4;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      default: state_d = ISSUE;
    endcase

    if (rst) req = 1'b0;

    if (!req || mem.mem_ack) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q == WAIT_LIMIT) begin
      timeout_d = 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ISSUE;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'd0;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
      instrF       <= 32'd0;
      pcF          <= 32'd0;
      PCPlus4F     <= 32'd0;
      validF       <= 1'b0;
      wait_cnt_q   <= 8'd0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instrF       <= instr_d;
      pcF          <= pcf_d;
      PCPlus4F     <= plus4_d;
      validF       <= valid_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_err  <= timeout_d;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int MAX_WAIT = 15;

  logic        clk;
  logic        rst;
  logic [1:0]  PCSrcF;
  logic [31:0] PCBranchF;
  logic [31:0] PCjumpF;
  logic        stallD;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic [31:0] PCPlus4F;
  logic        validF;
  logic        timeout_err;

  fetch_sequencer_if mem_bus();

  fetch_sequencer #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .PCSrcF(PCSrcF), .PCBranchF(PCBranchF), .PCjumpF(PCjumpF),
    .stallD(stallD), .mem(mem_bus), .instrF(instrF), .pcF(pcF), .PCPlus4F(PCPlus4F),
    .validF(validF), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  int consumed_cnt = 0;
  int lat_mode = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every instruction decode accepts must be the next one of the
  // expected in-order stream; the stream continues sequentially by default.
  always @(negedge clk) begin
    if (armed && !rst && validF === 1'b1 && !stallD) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got pc %h expected none", pcF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pcF", pcF, mon_e);
        chk("instrF", instrF, mem_word(mon_e));
        chk("PCPlus4F", PCPlus4F, mon_e + 32'd4);
        if (exp_q.size() == 0) exp_q.push_back(mon_e + 32'd4);
        consumed_cnt++;
      end
    end
  end

  // Memory responder with access-level model: address of each new access,
  // request/address stability, and sticky timeout expectation.
  logic [31:0] acc_addr;
  logic [31:0] next_acc_exp;
  bit          in_acc = 1'b0;
  bit          redir_pend = 1'b0;
  bit          to_exp = 1'b0;
  int          left = 0;
  int          unacked = 0;

  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'd0;
    next_acc_exp      = RESET_PC;
    acc_addr          = 32'd0;
    forever begin
      @(negedge clk);
      if (armed) chk("timeout_err", {31'd0, timeout_err}, {31'd0, to_exp});
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = $urandom;
      if (rst) begin
        in_acc       = 1'b0;
        redir_pend   = 1'b0;
        to_exp       = 1'b0;
        unacked      = 0;
        next_acc_exp = RESET_PC;
      end else if (armed) begin
        if (mem_bus.mem_req) begin
          if (!in_acc) begin
            in_acc   = 1'b1;
            acc_addr = mem_bus.mem_addr;
            unacked  = 0;
            chk("access_addr", mem_bus.mem_addr, next_acc_exp);
            case (lat_mode)
              0: left = 0;
              1: left = 3;
              2: left = int'($urandom_range(0, 4));
              default: left = 17;
            endcase
          end else begin
            chk("addr_stable", mem_bus.mem_addr, acc_addr);
          end
          if (left == 0) begin
            mem_bus.mem_ack   = 1'b1;
            mem_bus.mem_rdata = mem_word(acc_addr);
            in_acc            = 1'b0;
            if (!redir_pend) next_acc_exp = acc_addr + 32'd4;
            redir_pend = 1'b0;
          end else begin
            left--;
            unacked++;
            if (unacked == MAX_WAIT + 1) to_exp = 1'b1;
          end
        end else if (in_acc) begin
          checks++;
          errors++;
          $display("FAIL req_dropped: got req 0 expected 1 at addr %h", acc_addr);
          in_acc = 1'b0;
        end
        if ((PCSrcF == 2'b01 || PCSrcF == 2'b10) && !stallD) begin
          next_acc_exp = ((PCSrcF == 2'b10) ? PCjumpF : PCBranchF) & 32'hFFFF_FFFC;
          if (in_acc) redir_pend = 1'b1;
        end
      end
    end
  end

  task automatic drive_cycle(input bit s, input logic [1:0] src, input logic [31:0] br,
                             input logic [31:0] jp);
    @(posedge clk);
    #1;
    stallD = s;
    PCSrcF = src;
    PCBranchF = br;
    PCjumpF = jp;
    @(negedge clk);
    #1;
    if (!rst && (src == 2'b01 || src == 2'b10) && !s) begin
      exp_q.delete();
      exp_q.push_back(((src == 2'b10) ? jp : br) & 32'hFFFF_FFFC);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    stallD = 1'b0;
    PCSrcF = 2'b00;
    #1;
    chk("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
    @(posedge clk);
    #1;
    armed = 1'b1;
    chk("rst_validF", {31'd0, validF}, 32'd0);
    chk("rst_instrF", instrF, 32'd0);
    chk("rst_pcF", pcF, 32'd0);
    chk("rst_PCPlus4F", PCPlus4F, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst_mem_req_hold", {31'd0, mem_bus.mem_req}, 32'd0);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    rst = 1'b0;
  endtask

  int c0;
  int d;

  initial begin
    rst = 1'b1;
    stallD = 1'b0;
    PCSrcF = 2'b00;
    PCBranchF = 32'd0;
    PCjumpF = 32'd0;
    do_reset();

    // Zero-wait streaming: one instruction per cycle.
    lat_mode = 0;
    c0 = consumed_cnt;
    idle(20);
    chk("zero_wait_rate", consumed_cnt - c0, 32'd20);

    // Three-cycle memory latency.
    lat_mode = 1;
    c0 = consumed_cnt;
    idle(40);
    d = consumed_cnt - c0;
    checks++;
    if (d < 9 || d > 11) begin
      errors++;
      $display("FAIL lat3_rate: got %0d expected 9..11", d);
    end

    // Back-pressure into the skid buffer.
    lat_mode = 0;
    idle(6);
    drive_cycle(1'b1, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 2'b00, 32'd0, 32'd0);
      chk("skid_no_req", {31'd0, mem_bus.mem_req}, 32'd0);
      chk("skid_valid", {31'd0, validF}, 32'd1);
    end
    idle(6);

    // Branch while an access is outstanding.
    lat_mode = 1;
    idle(2);
    drive_cycle(1'b0, 2'b01, 32'h0000_0100, 32'h0000_0444);
    drive_cycle(1'b0, 2'b00, 32'd0, 32'd0);
    chk("branch_valid_drop", {31'd0, validF}, 32'd0);
    idle(20);

    // Jump with a same-cycle ack; low target bits are cleared.
    lat_mode = 0;
    idle(3);
    drive_cycle(1'b0, 2'b10, 32'h0000_0888, 32'h0000_0203);
    drive_cycle(1'b0, 2'b00, 32'd0, 32'd0);
    chk("jump_addr", mem_bus.mem_addr, 32'h0000_0200);
    chk("jump_valid_drop", {31'd0, validF}, 32'd0);
    idle(4);

    // Address wrap at the top of memory.
    drive_cycle(1'b0, 2'b10, 32'd0, 32'hFFFF_FFF8);
    idle(6);

    // Memory timeout, stickiness, and reset mid-wait.
    lat_mode = 3;
    idle(20);
    chk("timeout_set", {31'd0, timeout_err}, 32'd1);
    lat_mode = 0;
    idle(20);
    chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);
    lat_mode = 3;
    idle(5);
    do_reset();
    lat_mode = 0;
    idle(4);

    // Randomized traffic: latency, stalls, redirects (including 11).
    lat_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      bit s;
      logic [1:0] src;
      s = ($urandom_range(0, 9) < 3);
      src = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      drive_cycle(s, src, $urandom, $urandom);
    end
    lat_mode = 0;
    idle(12);

    checks++;
    if (consumed_cnt < 500) begin
      errors++;
      $display("FAIL throughput: got %0d expected at least 500", consumed_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Owns the fetch PC and sequences instruction fetches over a req/ack interface to a variable-latency instruction memory. Handles branch/jump redirects (PCSrcF) that arrive while an access is outstanding by draining and discarding wrong-path data. Presents fetched instructions to decode through a one-entry output register plus a one-entry skid buffer. Downstream back-pressure arrives on stallD.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (bits[1:0] must be 0)
MAX_WAIT, 15, unacked-cycle limit before timeout_err sets (1..255)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
PCSrcF  in  2  00 sequential, 01 branch, 10 jump, 11 ignored (treated as 00)
PCBranchF  in  32  branch target
PCjumpF  in  32  jump target
stallD  in  1  decode cannot accept this cycle
mem_req  out  1  memory access request
mem_addr  out  32  word address for the access
mem_ack  in  1  access complete, mem_rdata valid this cycle
mem_rdata  in  32  instruction word
instrF  out  32  fetched instruction
pcF  out  32  address of instrF
PCPlus4F  out  32  pcF + 4
validF  out  1  instrF/pcF/PCPlus4F are meaningful
timeout_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset (rst=1 at edge; wins over all other inputs): pc_q=RESET_PC, state=ISSUE, validF=0, instrF=0, pcF=0, PCPlus4F=0, skid empty, wait_cnt=0, timeout_err=0. mem_req=0 in any cycle where rst=1.
- redirect = (PCSrcF==01 or 10) && !stallD. Target = PCBranchF (01) or PCjumpF (10), bits[1:0] forced to 0. All adds are 32-bit with wrap-around (0xFFFF_FFFC+4 = 0).
- Output consumed in a cycle where validF && !stallD. slot_free = !validF || !stallD.
- Memory rule: once mem_req=1, mem_req and mem_addr stay stable until the cycle mem_ack=1. Ack may arrive in the same cycle as req (zero wait), giving one instruction per cycle.
- States: ISSUE, DRAIN, SKID.
- ISSUE: mem_req=1, mem_addr=pc_q.
  - redirect && mem_ack: drop rdata, pc_q<=target, validF<=0, stay ISSUE.
  - redirect && !mem_ack: latch old addr, pc_q<=target, validF<=0, go DRAIN.
  - mem_ack && slot_free: instrF<=rdata, pcF<=pc_q, PCPlus4F<=pc_q+4, validF<=1, pc_q<=pc_q+4, stay ISSUE.
  - mem_ack && !slot_free: rdata/pc_q into skid, pc_q<=pc_q+4, go SKID.
  - no ack: if validF consumed, validF<=0.
- DRAIN: mem_req=1, mem_addr=latched old addr. On mem_ack: discard rdata, go ISSUE. A further redirect in DRAIN updates pc_q only.
- SKID: mem_req=0. If redirect: empty skid, pc_q<=target, validF<=0, go ISSUE. Else if !stallD: skid->output, validF<=1, go ISSUE. Else hold.
- Order is strictly preserved: no instruction is lost or duplicated except wrong-path ones discarded by a redirect.
- wait_cnt: 0 on ack or when mem_req=0. Increments (saturating at MAX_WAIT) each cycle mem_req && !mem_ack. If mem_req && !mem_ack && wait_cnt==MAX_WAIT, timeout_err<=1. The flag stays set until rst. The access continues normally.
- Redirect while validF && stallD: not a redirect (gated by stallD). Target is ignored that cycle.

Test Plan:
1. RESET_PC=0, mem_ack=1 every cycle, stallD=0, PCSrcF=00 -> mem_addr 0,4,8,... each cycle. From first edge after rst: validF=1, pcF=0,4,8, PCPlus4F=4,8,12.
2. Ack 3 cycles after each req -> mem_req/mem_addr stable across waits. validF=1 for one cycle per ack. pcF steps by 4. timeout_err=0.
3. stallD=1 for 4 cycles while an ack lands with validF=1 -> state SKID, mem_req=0. Output held. On stallD=0 the skid word appears next cycle and fetch resumes at the next address. No gap or duplicate.
4. Req to 0x8 outstanding, PCSrcF=01, PCBranchF=0x100 -> validF=0. mem_addr stays 0x8 until ack. That data never appears on instrF. Next request addr=0x100.
5. PCSrcF=10, PCjumpF=0x203 with same-cycle mem_ack -> rdata dropped. Next mem_addr=0x200. Next instrF has pcF=0x200.
6. MAX_WAIT=15, ack withheld 17 cycles -> timeout_err rises after the 16th unacked cycle and stays 1 after the ack. rst=1 mid-wait -> mem_req=0, timeout_err=0, next addr=RESET_PC.
